// File: rtl/magnitude_acc_pkg.sv
// Shared definitions for the magnitude_acc slice: output/magnitude width helpers
// and the accumulator state encoding.
package magnitude_acc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_e;

   function automatic int mag_width(input int data_size);
      return 2 * data_size + 1;
   endfunction

   // Wide enough for 2^ACC_LEN_SIZE-1 full-scale magnitudes of either sign.
   function automatic int out_size(input int data_size, input int acc_len_size);
      return mag_width(data_size) + acc_len_size;
   endfunction

endpackage

// File: rtl/magnitude_acc_if.sv
// I/Q sample stream in, accumulated power stream out.
// master drives samples and window length; slave is the accumulator.
interface magnitude_acc_if
   import magnitude_acc_pkg::*;
#(
   parameter int DATA_SIZE    = 16,
   parameter int ACC_LEN_SIZE = 8,
   parameter int OUT_SIZE     = out_size(DATA_SIZE, ACC_LEN_SIZE)
) ();

   logic signed [DATA_SIZE-1:0] data_i_i;
   logic signed [DATA_SIZE-1:0] data_q_i;
   logic                        data_en_i;
   logic                        data_sof_i;
   logic                        data_eof_i;
   logic [ACC_LEN_SIZE-1:0]     acc_len_i;
   logic signed [OUT_SIZE-1:0]  data_o;
   logic                        data_en_o;
   logic                        data_sof_o;
   logic                        data_eof_o;

   modport master (
      output data_i_i, data_q_i, data_en_i, data_sof_i, data_eof_i, acc_len_i,
      input  data_o, data_en_o, data_sof_o, data_eof_o
   );

   modport slave (
      input  data_i_i, data_q_i, data_en_i, data_sof_i, data_eof_i, acc_len_i,
      output data_o, data_en_o, data_sof_o, data_eof_o
   );

endinterface

// File: rtl/magnitude_sq_pipe.sv
// Two-stage squared-magnitude pipe: registered I^2/Q^2, then registered sum with
// optional negation for negative-Q samples. Sideband flags travel alongside.
module magnitude_sq_pipe
   import magnitude_acc_pkg::*;
#(
   parameter int DATA_SIZE       = 16,
   parameter int SIGN_CORRECTION = 0
) (
   input  logic                                   data_clk_i,
   input  logic                                   data_rst_i,
   input  logic signed [DATA_SIZE-1:0]            data_i_i,
   input  logic signed [DATA_SIZE-1:0]            data_q_i,
   input  logic                                   data_en_i,
   input  logic                                   data_sof_i,
   input  logic                                   data_eof_i,
   output logic signed [mag_width(DATA_SIZE)-1:0] mag_o,
   output logic                                   en_o,
   output logic                                   sof_o,
   output logic                                   eof_o
);

   localparam int PROD_W = 2 * DATA_SIZE;
   localparam int MAG_W  = mag_width(DATA_SIZE);

   logic signed [PROD_W-1:0] i_sq_d, i_sq_q, q_sq_d, q_sq_q;
   logic                     en1_q, sof1_q, eof1_q, qneg1_q;
   logic signed [MAG_W-1:0]  sum_c, mag_d, mag_q;
   logic                     en2_q, sof2_q, eof2_q;

   assign i_sq_d = data_i_i * data_i_i;
   assign q_sq_d = data_q_i * data_q_i;

   // Products are non-negative, so the negated sum always fits in MAG_W.
   always_comb begin
      sum_c = MAG_W'(i_sq_q) + MAG_W'(q_sq_q);
      mag_d = sum_c;
      if ((SIGN_CORRECTION != 0) && qneg1_q) begin
         mag_d = -sum_c;
      end
   end

   always_ff @(posedge data_clk_i) begin
      if (data_rst_i) begin
         i_sq_q  <= '0;
         q_sq_q  <= '0;
         en1_q   <= 1'b0;
         sof1_q  <= 1'b0;
         eof1_q  <= 1'b0;
         qneg1_q <= 1'b0;
         mag_q   <= '0;
         en2_q   <= 1'b0;
         sof2_q  <= 1'b0;
         eof2_q  <= 1'b0;
      end else begin
         i_sq_q  <= i_sq_d;
         q_sq_q  <= q_sq_d;
         en1_q   <= data_en_i;
         sof1_q  <= data_en_i & data_sof_i;
         eof1_q  <= data_en_i & data_eof_i;
         qneg1_q <= data_q_i[DATA_SIZE-1];
         mag_q   <= mag_d;
         en2_q   <= en1_q;
         sof2_q  <= sof1_q;
         eof2_q  <= eof1_q;
      end
   end

   assign mag_o = mag_q;
   assign en_o  = en2_q;
   assign sof_o = sof2_q;
   assign eof_o = eof2_q;

endmodule

// File: rtl/magnitude_acc.sv
// Integrate-and-dump accumulator of I^2+Q^2 over sof/eof/length-bounded windows.
// Build option MAGNITUDE_ACC_DROP_CNT_EN adds drop_cnt_o (windows discarded by sof).
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | no open window; next valid sample opens one
// ST_ACC  | window open, count > 0, summing magnitudes
module magnitude_acc
   import magnitude_acc_pkg::*;
#(
   parameter int DATA_SIZE       = 16,
   parameter int ACC_LEN_SIZE    = 8,
   parameter int SIGN_CORRECTION = 0
) (
   input  logic        data_clk_i,
   input  logic        data_rst_i,
   magnitude_acc_if.slave bus,
`ifdef MAGNITUDE_ACC_DROP_CNT_EN
   output logic [15:0] drop_cnt_o,
`endif
   output logic        data_clk_o,
   output logic        data_rst_o
);

   localparam int OUT_SIZE = out_size(DATA_SIZE, ACC_LEN_SIZE);
   localparam int MAG_W    = mag_width(DATA_SIZE);

   logic signed [MAG_W-1:0]    s2_mag;
   logic                       s2_en, s2_sof, s2_eof;
   logic signed [OUT_SIZE-1:0] mag_ext;

   acc_state_e                 state_q, state_d;
   logic [ACC_LEN_SIZE-1:0]    cnt_q, cnt_d, cnt_new;
   logic [ACC_LEN_SIZE-1:0]    len_q, len_d, len_new;
   logic signed [OUT_SIZE-1:0] acc_q, acc_d, sum_new;
   logic                       wsof_q, wsof_d, wsof_new;
   logic                       open_c, dump_c, discard_c;
   logic signed [OUT_SIZE-1:0] data_q, data_d;
   logic                       en_q, en_d, sof_q, sof_d, eof_q, eof_d;

   magnitude_sq_pipe #(
      .DATA_SIZE       (DATA_SIZE),
      .SIGN_CORRECTION (SIGN_CORRECTION)
   ) u_sq_pipe (
      .data_clk_i (data_clk_i),
      .data_rst_i (data_rst_i),
      .data_i_i   (bus.data_i_i),
      .data_q_i   (bus.data_q_i),
      .data_en_i  (bus.data_en_i),
      .data_sof_i (bus.data_sof_i),
      .data_eof_i (bus.data_eof_i),
      .mag_o      (s2_mag),
      .en_o       (s2_en),
      .sof_o      (s2_sof),
      .eof_o      (s2_eof)
   );

   assign mag_ext = OUT_SIZE'(s2_mag);

   // Window arithmetic shared by next-state and output logic.
   always_comb begin
      open_c    = s2_en && ((state_q == ST_IDLE) || s2_sof);
      discard_c = open_c && (state_q == ST_ACC);
      if (open_c) begin
         sum_new  = mag_ext;
         cnt_new  = ACC_LEN_SIZE'(1);
         len_new  = (bus.acc_len_i == '0) ? ACC_LEN_SIZE'(1) : bus.acc_len_i;
         wsof_new = s2_sof;
      end else begin
         sum_new  = acc_q + mag_ext;
         cnt_new  = cnt_q + ACC_LEN_SIZE'(1);
         len_new  = len_q;
         wsof_new = wsof_q;
      end
      dump_c = s2_en && ((cnt_new == len_new) || s2_eof);
   end

   always_ff @(posedge data_clk_i) begin
      if (data_rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (s2_en) begin
         state_d = dump_c ? ST_IDLE : ST_ACC;
      end
   end

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      len_d  = len_q;
      wsof_d = wsof_q;
      data_d = data_q;
      en_d   = 1'b0;
      sof_d  = 1'b0;
      eof_d  = 1'b0;
      if (s2_en) begin
         if (dump_c) begin
            data_d = sum_new;
            en_d   = 1'b1;
            sof_d  = wsof_new;
            eof_d  = s2_eof;
            acc_d  = '0;
            cnt_d  = '0;
            len_d  = len_new;
            wsof_d = 1'b0;
         end else begin
            acc_d  = sum_new;
            cnt_d  = cnt_new;
            len_d  = len_new;
            wsof_d = wsof_new;
         end
      end
   end

   always_ff @(posedge data_clk_i) begin
      if (data_rst_i) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
         wsof_q <= 1'b0;
         data_q <= '0;
         en_q   <= 1'b0;
         sof_q  <= 1'b0;
         eof_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         len_q  <= len_d;
         wsof_q <= wsof_d;
         data_q <= data_d;
         en_q   <= en_d;
         sof_q  <= sof_d;
         eof_q  <= eof_d;
      end
   end

`ifdef MAGNITUDE_ACC_DROP_CNT_EN
   logic [15:0] drop_q;

   always_ff @(posedge data_clk_i) begin
      if (data_rst_i) begin
         drop_q <= '0;
      end else if (discard_c && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign drop_cnt_o = drop_q;
`endif

   assign bus.data_o     = data_q;
   assign bus.data_en_o  = en_q;
   assign bus.data_sof_o = sof_q;
   assign bus.data_eof_o = eof_q;
   assign data_clk_o     = data_clk_i;
   assign data_rst_o     = data_rst_i;

endmodule
